// File: rtl/fmc_pkg.sv
// Shared definitions for the FMC clock-select sequencer: path-select codes,
// sequencer states and counter widths.
package fmc_pkg;

  localparam int N_W = 3;
  localparam int M_W = 2;

  localparam logic [1:0] SEL_RING = 2'b00;
  localparam logic [1:0] SEL_INJ  = 2'b01;
  localparam logic [1:0] SEL_DIV  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN
  } state_t;

  // The injection slot wins over the plain divided edge when both flags are set.
  function automatic logic [1:0] sel_code(input logic div_n, input logic div_m);
    if (div_m)
      return SEL_INJ;
    else if (div_n)
      return SEL_DIV;
    else
      return SEL_RING;
  endfunction

endpackage

// File: rtl/fmc_frame_counter.sv
// Nested N/M frame counter. The wrap flags are registered together with the
// counts, so the current flags decide the wrap and the next limits the new flags.
module fmc_frame_counter
  import fmc_pkg::*;
(
  input  logic           clk_out,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           start,
  input  logic [N_W-1:0] n_lim,
  input  logic [M_W-1:0] m_lim,
  output logic [N_W-1:0] n_cnt,
  output logic [M_W-1:0] m_cnt,
  output logic           div_n,
  output logic           div_m,
  output logic           div_n_d,
  output logic           div_m_d
);

  logic [N_W-1:0] n_d;
  logic [M_W-1:0] m_d;

  // n_lim/m_lim are the limits in force during the cycle being computed.
  always_comb begin
    n_d = '0;
    m_d = '0;
    if (!clear && !start) begin
      n_d = div_n ? '0 : n_cnt + 1'b1;
      if (div_m)
        m_d = '0;
      else if (div_n)
        m_d = m_cnt + 1'b1;
      else
        m_d = m_cnt;
    end
    div_n_d = !clear && (n_d == n_lim);
    div_m_d = div_n_d && (m_d == m_lim);
  end

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      n_cnt <= '0;
      m_cnt <= '0;
      div_n <= 1'b0;
      div_m <= 1'b0;
    end else begin
      n_cnt <= n_d;
      m_cnt <= m_d;
      div_n <= div_n_d;
      div_m <= div_m_d;
    end
  end

endmodule

// File: rtl/fmc_sel_sequencer.sv
// FMC clock-select sequencer: aligns the N/M count frame to the external
// reference, steers the delay-line input and tracks lock through missed edges.
module fmc_sel_sequencer
  import fmc_pkg::*;
#(
  parameter int MISS_LIMIT = 3
) (
  input  logic           clk_out,
  input  logic           rst_n,
  input  logic           en,
  input  logic           ext_edge,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [N_W-1:0] cfg_n,
  input  logic [M_W-1:0] cfg_m,
  output logic [N_W-1:0] N_counter,
  output logic [M_W-1:0] M_counter,
  output logic           DIV_N,
  output logic           DIV_M,
  output logic [1:0]     Sel,
  output logic           locked,
  output logic           missed_edge
);

  state_t         state_q;
  state_t         nxt_state;
  logic [N_W-1:0] n_q, n_p, n_q_d;
  logic [M_W-1:0] m_q, m_p, m_q_d;
  logic           pend, pend_d;
  logic [1:0]     miss_cnt;
  logic [2:0]     miss_next;
  logic           hs, slot, limit_hit, stay_run, commit;
  logic           div_n_d, div_m_d;

  fmc_frame_counter u_frame (
    .clk_out (clk_out),
    .rst_n   (rst_n),
    .clear   (nxt_state != ST_RUN),
    .start   (state_q != ST_RUN),
    .n_lim   (n_q_d),
    .m_lim   (m_q_d),
    .n_cnt   (N_counter),
    .m_cnt   (M_counter),
    .div_n   (DIV_N),
    .div_m   (DIV_M),
    .div_n_d (div_n_d),
    .div_m_d (div_m_d)
  );

  // A ratio accepted outside a running frame, or on the edge that leaves RUN,
  // goes straight into n_q/m_q; inside RUN it waits for the frame end.
  always_comb begin
    hs        = cfg_valid && cfg_ready;
    slot      = (state_q == ST_RUN) && DIV_M;
    miss_next = {1'b0, miss_cnt} + 3'd1;
    limit_hit = slot && !ext_edge && (miss_next >= 3'(MISS_LIMIT));

    nxt_state = state_q;
    if (!en) begin
      nxt_state = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: nxt_state = ST_ARM;
        ST_ARM:  if (ext_edge) nxt_state = ST_RUN;
        ST_RUN:  if (limit_hit) nxt_state = ST_ARM;
        default: nxt_state = ST_IDLE;
      endcase
    end

    stay_run = (state_q == ST_RUN) && (nxt_state == ST_RUN);
    commit   = pend && (slot || !stay_run);

    n_q_d = n_q;
    m_q_d = m_q;
    if (commit) begin
      n_q_d = n_p;
      m_q_d = m_p;
    end
    if (hs && !stay_run) begin
      n_q_d = cfg_n;
      m_q_d = cfg_m;
    end

    pend_d = pend;
    if (commit)
      pend_d = 1'b0;
    if (hs && stay_run)
      pend_d = 1'b1;
  end

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      n_q         <= '0;
      m_q         <= '0;
      n_p         <= '0;
      m_p         <= '0;
      pend        <= 1'b0;
      miss_cnt    <= '0;
      locked      <= 1'b0;
      missed_edge <= 1'b0;
      Sel         <= SEL_RING;
      cfg_ready   <= 1'b1;
    end else begin
      state_q   <= nxt_state;
      n_q       <= n_q_d;
      m_q       <= m_q_d;
      pend      <= pend_d;
      cfg_ready <= (nxt_state == ST_RUN) ? !pend_d : 1'b1;
      Sel       <= sel_code(div_n_d, div_m_d);
      if (hs && stay_run) begin
        n_p <= cfg_n;
        m_p <= cfg_m;
      end

      missed_edge <= en && slot && !ext_edge;
      locked      <= (nxt_state == ST_RUN) && (locked || (slot && ext_edge));

      // Leaving RUN restarts the miss history for the next alignment.
      if (nxt_state != ST_RUN)
        miss_cnt <= '0;
      else if (slot && ext_edge)
        miss_cnt <= '0;
      else if (slot)
        miss_cnt <= (miss_cnt == 2'd3) ? 2'd3 : miss_cnt + 2'd1;
    end
  end

endmodule
